cache_miss_alloc: RTL and testbench
===================================

# cache_miss_alloc

Miss-allocation controller for the set-associative cache. It is the driving side of the replacement-policy interface: on a lookup miss it reads the victim choice for the set and writes back the victim if it is valid and dirty. It then requests the refill and finally drives the single-cycle update (`line_addr`, one-hot `way_hit`, `write_en`) that advances the policy state. It sits between the cache lookup stage, the valid/dirty memories, the replacement policy, and the back-end (write-back and refill) interface.

## Interface
The block has one clock; reset is synchronous and active-low.

**Parameters**
- `N_WAYS`, default 8: associativity; must be a power of two, ≥ 2.
- `NWAY_W`, default `$clog2(N_WAYS)`: way index width.
- `LINE_OFF_W`, default 7: set index width.
- `TAG_W`, default 20: tag width.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-low reset.
- `miss_req`, in, 1: single-cycle miss pulse; sampled only in IDLE.
- `miss_line`, in, LINE_OFF_W: set index of the miss.
- `miss_tag`, in, TAG_W: tag of the miss.
- `valid_way`, in, N_WAYS: valid bits of the addressed set.
- `dirty_way`, in, N_WAYS: dirty bits of the addressed set.
- `way_select_bin`, in, NWAY_W: victim way index from the replacement policy.
- `rp_line_addr`, out, LINE_OFF_W: set index presented to the policy memory.
- `rp_way_hit`, out, N_WAYS: one-hot code of the filled way.
- `rp_write_en`, out, 1: policy-state update strobe.
- `wb_req`, out, 1: write-back request.
- `wb_ack`, in, 1: write-back acknowledge.
- `wb_way`, out, NWAY_W: way to write back.
- `fill_req`, out, 1: refill request.
- `fill_ack`, in, 1: refill acknowledge.
- `fill_way`, out, NWAY_W: way to fill.
- `fill_line`, out, LINE_OFF_W: set index to fill.
- `fill_tag`, out, TAG_W: tag to fill.
- `miss_ack`, out, 1: allocation-complete pulse.
- `busy`, out, 1: high in every state except IDLE.

## Operation
**States**
- IDLE
  - `busy`=0; `rp_line_addr` follows `miss_line`.
  - When `miss_req`=1: latch `miss_line` into line_q and `miss_tag` into tag_q, then go to SELECT.
- SELECT
  - `rp_line_addr` = line_q.
  - Victim selection (see Configuration) latches victim_q.
  - If `valid_way[victim]` and `dirty_way[victim]` are both 1, go to WB; otherwise go to FILL.
- WB
  - `wb_req`=1 and `wb_way`=victim_q.
  - On `wb_ack`=1, go to FILL.
- FILL
  - `fill_req`=1, `fill_way`=victim_q, `fill_line`=line_q, `fill_tag`=tag_q.
  - On `fill_ack`=1, go to UPDATE.
- UPDATE
  - For exactly one cycle: `rp_write_en`=1, `rp_way_hit` = 1<<victim_q, `rp_line_addr`=line_q, `miss_ack`=1.
  - Next state is IDLE.

**Handshake and output rules**
- A request stays high until it is acknowledged. An ack sampled in the same cycle that the request first rises is accepted.
- An ack outside its own state is ignored.
- A `miss_req` that arrives while `busy`=1 is dropped. The requester must not issue one.
- `rp_way_hit` is all-zero and `rp_write_en` is 0 outside UPDATE, so the policy state is never touched mid-miss.
- `wb_way`, `fill_*` and `rp_way_hit` are driven from registered victim_q and line_q/tag_q. These outputs are stable for the whole handshake.

## Timing
- Reset (`reset`=0 at a clock edge): state goes to IDLE, and all outputs and registers go to 0. Any outstanding `wb_req` or `fill_req` is abandoned. The requester must reissue the miss.
- Minimum latency is 3 cycles. Example: `miss_req` at cycle 0, SELECT at cycle 1, FILL at cycle 2 with `fill_ack` in the same cycle, then UPDATE with `miss_ack` at cycle 3, then IDLE at cycle 4.
- A dirty victim adds at least 1 cycle, plus the `wb_ack` wait.
- The policy read is combinational. `way_select_bin` is valid in SELECT because `rp_line_addr`=line_q from that cycle on.

## Configuration
The macro `CACHE_INVALID_FIRST_EN` controls victim selection in SELECT.
- **Defined:** if any `valid_way` bit is 0, the victim is the lowest-index invalid way. Otherwise the victim is `way_select_bin`.
- **Undefined:** the victim is always `way_select_bin`, and `valid_way` is used only for the dirty-victim check.

## Structure
- Shared package (cache include):
  - state encoding: IDLE=0, SELECT=1, WB=2, FILL=3, UPDATE=4, on a 3-bit field;
  - the `CACHE_INVALID_FIRST_EN` default.
- One sub-module, `cache_first_invalid`.
  - Parameterised N_WAYS priority encoder.
  - Outputs: `any_invalid`, plus an NWAY_W index of the lowest 0 bit.
  - Instantiated only under the macro.

## Test plan
Default parameters (N_WAYS=8) unless stated otherwise.
1. Clean victim:
   - Stimulus: `miss_req` with line=5, tag=0x1234; `valid_way`=0xFF; `dirty_way`=0x00; `way_select_bin`=3; `fill_ack` held at 1.
   - Required: `fill_req` at cycle 2 with way=3, line=5, tag=0x1234; at cycle 3, `miss_ack`=1, `rp_write_en`=1, `rp_way_hit`=0x08; no `wb_req`.
2. Dirty victim:
   - Stimulus: `dirty_way`=0x08, victim 3; `wb_ack` delayed 4 cycles.
   - Required: `wb_req` held 4 cycles with `wb_way`=3, then FILL, then UPDATE; `rp_way_hit`=0x08.
3. Invalid-first, with the macro defined:
   - Stimulus: `valid_way`=0xEB, `way_select_bin`=6.
   - Required: victim=2 (lowest invalid), `rp_way_hit`=0x04.
   - Same stimulus without the macro: victim=6.
4. Busy drop:
   - Stimulus: a second `miss_req` (line=9) during FILL.
   - Required: it is ignored; UPDATE reports line 5 only; `busy` stays 1 until IDLE.
5. Reset mid-operation:
   - Stimulus: `reset`=0 while `wb_req`=1.
   - Required: next cycle all outputs are 0 and state is IDLE; a later `wb_ack` has no effect.
6. Back-to-back misses:
   - Stimulus: `miss_req` in the first IDLE cycle after `miss_ack`.
   - Required: accepted; second `miss_ack` exactly 4 cycles after the first, with acks held at 1 and a clean victim.

Source files
------------

// File: rtl/cache_miss_alloc_pkg.sv
// Shared definitions for the miss-allocation controller: FSM state encoding and
// the invalid-first victim selection default (macro CACHE_INVALID_FIRST_EN).
package cache_miss_alloc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_WB     = 3'd2,
    ST_FILL   = 3'd3,
    ST_UPDATE = 3'd4
  } alloc_state_e;

`ifdef CACHE_INVALID_FIRST_EN
  localparam bit INVALID_FIRST_EN = 1'b1;
`else
  localparam bit INVALID_FIRST_EN = 1'b0;
`endif

endpackage

// File: rtl/cache_miss_alloc_first_invalid.sv
// Priority encoder over a set's valid bits: flags any invalid way and returns
// the index of the lowest-numbered one.
module cache_first_invalid #(
  parameter int N_WAYS = 8,
  parameter int NWAY_W = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] valid_way,
  output logic              any_invalid,
  output logic [NWAY_W-1:0] first_idx
);

  // Scan downwards so the lowest invalid index is the last one written.
  always_comb begin
    any_invalid = 1'b0;
    first_idx   = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (!valid_way[i]) begin
        any_invalid = 1'b1;
        first_idx   = NWAY_W'(i);
      end
    end
  end

endmodule

// File: rtl/cache_miss_alloc.sv
// Miss-allocation controller: picks a victim, writes it back if dirty, refills,
// then strobes a one-cycle policy update. CACHE_INVALID_FIRST_EN prefers invalid ways.
module cache_miss_alloc
  import cache_miss_alloc_pkg::*;
#(
  parameter int N_WAYS     = 8,
  parameter int NWAY_W     = $clog2(N_WAYS),
  parameter int LINE_OFF_W = 7,
  parameter int TAG_W      = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_req,
  input  logic [LINE_OFF_W-1:0] miss_line,
  input  logic [TAG_W-1:0]      miss_tag,
  input  logic [N_WAYS-1:0]     valid_way,
  input  logic [N_WAYS-1:0]     dirty_way,
  input  logic [NWAY_W-1:0]     way_select_bin,
  output logic [LINE_OFF_W-1:0] rp_line_addr,
  output logic [N_WAYS-1:0]     rp_way_hit,
  output logic                  rp_write_en,
  output logic                  wb_req,
  input  logic                  wb_ack,
  output logic [NWAY_W-1:0]     wb_way,
  output logic                  fill_req,
  input  logic                  fill_ack,
  output logic [NWAY_W-1:0]     fill_way,
  output logic [LINE_OFF_W-1:0] fill_line,
  output logic [TAG_W-1:0]      fill_tag,
  output logic                  miss_ack,
  output logic                  busy
);

  alloc_state_e          state_q;
  logic [LINE_OFF_W-1:0] line_q;
  logic [TAG_W-1:0]      tag_q;
  logic [NWAY_W-1:0]     victim_q;
  logic [NWAY_W-1:0]     victim;
  logic [N_WAYS-1:0]     one_way;

  assign one_way = {{(N_WAYS-1){1'b0}}, 1'b1};

`ifdef CACHE_INVALID_FIRST_EN
  logic              any_invalid;
  logic [NWAY_W-1:0] first_idx;

  cache_first_invalid #(
    .N_WAYS(N_WAYS),
    .NWAY_W(NWAY_W)
  ) u_first_invalid (
    .valid_way  (valid_way),
    .any_invalid(any_invalid),
    .first_idx  (first_idx)
  );

  assign victim = any_invalid ? first_idx : way_select_bin;
`else
  assign victim = way_select_bin;
`endif

  // The policy read is combinational, so the set index must switch to line_q
  // the moment SELECT is entered.
  assign rp_line_addr = (state_q == ST_IDLE) ? miss_line : line_q;
  assign wb_way       = victim_q;
  assign fill_way     = victim_q;
  assign fill_line    = line_q;
  assign fill_tag     = tag_q;

  // Handshake: wb_req/fill_req rise on state entry and hold until their ack is
  // sampled high in their own state; an ack in the entry cycle is accepted,
  // acks elsewhere are ignored, and miss_req is only sampled in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      tag_q       <= '0;
      victim_q    <= '0;
      rp_way_hit  <= '0;
      rp_write_en <= 1'b0;
      wb_req      <= 1'b0;
      fill_req    <= 1'b0;
      miss_ack    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_req) begin
            line_q  <= miss_line;
            tag_q   <= miss_tag;
            busy    <= 1'b1;
            state_q <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          victim_q <= victim;
          if (valid_way[victim] && dirty_way[victim]) begin
            wb_req  <= 1'b1;
            state_q <= ST_WB;
          end else begin
            fill_req <= 1'b1;
            state_q  <= ST_FILL;
          end
        end
        ST_WB: begin
          if (wb_ack) begin
            wb_req   <= 1'b0;
            fill_req <= 1'b1;
            state_q  <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (fill_ack) begin
            fill_req    <= 1'b0;
            rp_write_en <= 1'b1;
            miss_ack    <= 1'b1;
            rp_way_hit  <= one_way << victim_q;
            state_q     <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          rp_write_en <= 1'b0;
          miss_ack    <= 1'b0;
          rp_way_hit  <= '0;
          busy        <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_alloc.sv
// Directed bench for cache_miss_alloc: clean/dirty victims, victim choice,
// busy drop, reset abandon and back-to-back misses.
module tb_cache_miss_alloc;

  localparam int N_WAYS = 8;
  localparam int NWAY_W = 3;
  localparam int LW     = 7;
  localparam int TW     = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              miss_req;
  logic [LW-1:0]     miss_line;
  logic [TW-1:0]     miss_tag;
  logic [N_WAYS-1:0] valid_way;
  logic [N_WAYS-1:0] dirty_way;
  logic [NWAY_W-1:0] way_select_bin;
  logic [LW-1:0]     rp_line_addr;
  logic [N_WAYS-1:0] rp_way_hit;
  logic              rp_write_en;
  logic              wb_req;
  logic              wb_ack;
  logic [NWAY_W-1:0] wb_way;
  logic              fill_req;
  logic              fill_ack;
  logic [NWAY_W-1:0] fill_way;
  logic [LW-1:0]     fill_line;
  logic [TW-1:0]     fill_tag;
  logic              miss_ack;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cache_miss_alloc #(
    .N_WAYS(N_WAYS), .NWAY_W(NWAY_W), .LINE_OFF_W(LW), .TAG_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_line(miss_line),
    .miss_tag(miss_tag), .valid_way(valid_way), .dirty_way(dirty_way),
    .way_select_bin(way_select_bin), .rp_line_addr(rp_line_addr),
    .rp_way_hit(rp_way_hit), .rp_write_en(rp_write_en), .wb_req(wb_req),
    .wb_ack(wb_ack), .wb_way(wb_way), .fill_req(fill_req), .fill_ack(fill_ack),
    .fill_way(fill_way), .fill_line(fill_line), .fill_tag(fill_tag),
    .miss_ack(miss_ack), .busy(busy)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_miss(input logic [LW-1:0] line, input logic [TW-1:0] tag);
    miss_line = line;
    miss_tag  = tag;
    miss_req  = 1'b1;
    tick();
    miss_req  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; miss_req = 1'b0; miss_line = '0; miss_tag = '0;
    valid_way = '0; dirty_way = '0; way_select_bin = '0; wb_ack = 1'b0; fill_ack = 1'b0;
    tick(); tick();
    reset = 1'b1;
    checks++;
    if ({busy, wb_req, fill_req, miss_ack, rp_write_en} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, wb_req, fill_req, miss_ack, rp_write_en});
    end
    checks++;
    if ({rp_way_hit, wb_way, fill_way, fill_line, fill_tag} !== '0) begin
      errors++; $display("FAIL reset_data: way_hit=%h fill_tag=%h want 0", rp_way_hit, fill_tag);
    end
  endtask

  task automatic test_clean_victim();
    valid_way = 8'hFF; dirty_way = 8'h00; way_select_bin = 3'd3; fill_ack = 1'b1; wb_ack = 1'b0;
    start_miss(7'd5, 20'h01234);              // now cycle 1 (SELECT)
    checks++;
    if (busy !== 1'b1 || rp_line_addr !== 7'd5 || fill_req !== 1'b0) begin
      errors++; $display("FAIL clean_select: busy=%b line=%0d fill_req=%b want 1,5,0", busy, rp_line_addr, fill_req);
    end
    tick();                                   // cycle 2 (FILL)
    checks++;
    if (fill_req !== 1'b1 || fill_way !== 3'd3 || fill_line !== 7'd5 || fill_tag !== 20'h01234 || wb_req !== 1'b0) begin
      errors++; $display("FAIL clean_fill: req=%b way=%0d line=%0d tag=%h wb=%b want 1,3,5,01234,0",
                         fill_req, fill_way, fill_line, fill_tag, wb_req);
    end
    tick();                                   // cycle 3 (UPDATE)
    checks++;
    if (miss_ack !== 1'b1 || rp_write_en !== 1'b1 || rp_way_hit !== 8'h08 || rp_line_addr !== 7'd5) begin
      errors++; $display("FAIL clean_update: ack=%b we=%b hit=%h line=%0d want 1,1,08,5",
                         miss_ack, rp_write_en, rp_way_hit, rp_line_addr);
    end
    tick();                                   // cycle 4 (IDLE)
    checks++;
    if (busy !== 1'b0 || miss_ack !== 1'b0 || rp_write_en !== 1'b0 || rp_way_hit !== 8'h00) begin
      errors++; $display("FAIL clean_idle: busy=%b ack=%b we=%b hit=%h want 0,0,0,00", busy, miss_ack, rp_write_en, rp_way_hit);
    end
  endtask

  task automatic test_dirty_victim();
    valid_way = 8'hFF; dirty_way = 8'h08; way_select_bin = 3'd3; fill_ack = 1'b1; wb_ack = 1'b0;
    start_miss(7'd17, 20'hABCDE);
    tick();                                   // cycle 2: WB entered
    for (int i = 0; i < 4; i++) begin
      if (i == 3) wb_ack = 1'b1;
      checks++;
      if (wb_req !== 1'b1 || wb_way !== 3'd3 || fill_req !== 1'b0 || rp_way_hit !== 8'h00) begin
        errors++; $display("FAIL dirty_wb[%0d]: wb_req=%b way=%0d fill_req=%b hit=%h want 1,3,0,00",
                           i, wb_req, wb_way, fill_req, rp_way_hit);
      end
      tick();
    end
    wb_ack = 1'b0;
    checks++;
    if (wb_req !== 1'b0 || fill_req !== 1'b1 || fill_way !== 3'd3 || fill_tag !== 20'hABCDE) begin
      errors++; $display("FAIL dirty_fill: wb_req=%b fill_req=%b way=%0d tag=%h want 0,1,3,abcde",
                         wb_req, fill_req, fill_way, fill_tag);
    end
    tick();
    checks++;
    if (miss_ack !== 1'b1 || rp_write_en !== 1'b1 || rp_way_hit !== 8'h08 || rp_line_addr !== 7'd17) begin
      errors++; $display("FAIL dirty_update: ack=%b we=%b hit=%h line=%0d want 1,1,08,17",
                         miss_ack, rp_write_en, rp_way_hit, rp_line_addr);
    end
    tick();
  endtask

  task automatic test_victim_choice();
    logic [NWAY_W-1:0] exp_way;
    logic [N_WAYS-1:0] exp_hit;
`ifdef CACHE_INVALID_FIRST_EN
    exp_way = 3'd2;
`else
    exp_way = 3'd6;
`endif
    exp_hit = 8'h01 << exp_way;
    valid_way = 8'hEB; dirty_way = 8'h00; way_select_bin = 3'd6; fill_ack = 1'b1;
    start_miss(7'd33, 20'h00042);
    tick();
    checks++;
    if (fill_req !== 1'b1 || fill_way !== exp_way) begin
      errors++; $display("FAIL victim_way: fill_req=%b way=%0d want 1,%0d", fill_req, fill_way, exp_way);
    end
    tick();
    checks++;
    if (rp_way_hit !== exp_hit || miss_ack !== 1'b1) begin
      errors++; $display("FAIL victim_hit: hit=%h ack=%b want %h,1", rp_way_hit, miss_ack, exp_hit);
    end
    tick();
  endtask

  task automatic test_busy_drop();
    valid_way = 8'hFF; dirty_way = 8'h00; way_select_bin = 3'd1; fill_ack = 1'b0;
    start_miss(7'd5, 20'h00555);
    tick();                                   // cycle 2: FILL, stall it
    miss_line = 7'd9; miss_tag = 20'h99999; miss_req = 1'b1;
    tick();
    miss_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || fill_req !== 1'b1 || fill_line !== 7'd5 || fill_tag !== 20'h00555) begin
      errors++; $display("FAIL drop_fill: busy=%b req=%b line=%0d tag=%h want 1,1,5,00555", busy, fill_req, fill_line, fill_tag);
    end
    fill_ack = 1'b1;
    tick();
    checks++;
    if (miss_ack !== 1'b1 || rp_line_addr !== 7'd5 || busy !== 1'b1 || rp_way_hit !== 8'h02) begin
      errors++; $display("FAIL drop_update: ack=%b line=%0d busy=%b hit=%h want 1,5,1,02", miss_ack, rp_line_addr, busy, rp_way_hit);
    end
    miss_line = 7'd0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || fill_req !== 1'b0 || miss_ack !== 1'b0) begin
      errors++; $display("FAIL drop_idle: busy=%b fill_req=%b ack=%b want 0,0,0", busy, fill_req, miss_ack);
    end
  endtask

  task automatic test_reset_mid();
    valid_way = 8'hFF; dirty_way = 8'hFF; way_select_bin = 3'd6; fill_ack = 1'b0; wb_ack = 1'b0;
    start_miss(7'd44, 20'hFEDCB);
    tick();
    checks++;
    if (wb_req !== 1'b1 || wb_way !== 3'd6) begin
      errors++; $display("FAIL rst_pre: wb_req=%b way=%0d want 1,6", wb_req, wb_way);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({busy, wb_req, fill_req, miss_ack, rp_write_en} !== 5'b0 ||
        {rp_way_hit, wb_way, fill_way, fill_line, fill_tag} !== '0) begin
      errors++; $display("FAIL rst_mid: ctrl=%b wb_way=%0d fill_line=%0d tag=%h want all 0",
                         {busy, wb_req, fill_req, miss_ack, rp_write_en}, wb_way, fill_line, fill_tag);
    end
    wb_ack = 1'b1; fill_ack = 1'b1;
    tick(); tick();
    wb_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || fill_req !== 1'b0 || wb_req !== 1'b0 || miss_ack !== 1'b0) begin
      errors++; $display("FAIL rst_late_ack: busy=%b fill=%b wb=%b ack=%b want 0,0,0,0", busy, fill_req, wb_req, miss_ack);
    end
  endtask

  task automatic test_back_to_back();
    int  first_cyc;
    int  second_cyc;
    bit  seen;
    valid_way = 8'hFF; dirty_way = 8'h00; way_select_bin = 3'd0; fill_ack = 1'b1; wb_ack = 1'b1;
    first_cyc = -1; second_cyc = -1;
    start_miss(7'd1, 20'h00001);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (miss_ack === 1'b1) begin seen = 1'b1; first_cyc = cyc; end
      else tick();
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL b2b_first: miss_ack=0 after 10 cycles want 1");
    end
    tick();
    start_miss(7'd2, 20'h00002);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (miss_ack === 1'b1) begin seen = 1'b1; second_cyc = cyc; end
      else tick();
    end
    checks++;
    if (!seen || second_cyc - first_cyc != 4 || rp_line_addr !== 7'd2 || rp_way_hit !== 8'h01) begin
      errors++; $display("FAIL b2b_second: seen=%b gap=%0d line=%0d hit=%h want 1,4,2,01",
                         seen, second_cyc - first_cyc, rp_line_addr, rp_way_hit);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_victim();
    test_dirty_victim();
    test_victim_choice();
    test_busy_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
